// File: rtl/mlp_pkg.sv
// Shared types, default widths and clamp-limit helpers for the tiny-MLP datapath.
package mlp_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_EMIT  = 1'b1
    } state_e;

    localparam int unsigned DEF_IN_W     = 4;
    localparam int unsigned DEF_W_W      = 4;
    localparam int unsigned DEF_ACC_W    = 16;
    localparam int unsigned DEF_N_INPUTS = 4;
    localparam int unsigned DEF_SATURATE = 1;

    // Wide enough to hold the clamp limits of any practical accumulator width
    localparam int unsigned LIM_W = 64;

    // Largest positive value of a w-bit signed number, in LIM_W bits
    function automatic logic [LIM_W-1:0] sat_max(input int unsigned w);
        return (LIM_W'(1) << (w - 1)) - LIM_W'(1);
    endfunction

    // Most negative value of a w-bit signed number; truncate to w bits at use
    function automatic logic [LIM_W-1:0] sat_min(input int unsigned w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/mlp_sat_add.sv
// Combinational signed adder with overflow detect and optional clamping.
module mlp_sat_add
    import mlp_pkg::*;
#(
    parameter int unsigned ACC_W    = DEF_ACC_W,
    parameter int unsigned SATURATE = DEF_SATURATE
) (
    input  logic signed [ACC_W-1:0] i_a,
    input  logic signed [ACC_W-1:0] i_b,
    output logic signed [ACC_W-1:0] o_sum_c,
    output logic                    o_ovf_c
);

    localparam logic [ACC_W-1:0] MAX_V = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] MIN_V = ACC_W'(sat_min(ACC_W));

    logic signed [ACC_W-1:0] w_raw;
    logic                    w_ovf;

    // Overflow when both operands share a sign that the result does not
    always_comb begin
        w_raw   = i_a + i_b;
        w_ovf   = (i_a[ACC_W-1] == i_b[ACC_W-1]) && (w_raw[ACC_W-1] != i_a[ACC_W-1]);
        o_ovf_c = w_ovf;
        o_sum_c = w_raw;
        if ((SATURATE != 0) && w_ovf) begin
            o_sum_c = i_a[ACC_W-1] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/mlp_neuron_mac.sv
// Single-neuron MAC: streams (act, weight) beats onto a bias, emits sum and ReLU.
module mlp_neuron_mac
    import mlp_pkg::*;
#(
    parameter int unsigned IN_W     = DEF_IN_W,
    parameter int unsigned W_W      = DEF_W_W,
    parameter int unsigned ACC_W    = DEF_ACC_W,
    parameter int unsigned N_INPUTS = DEF_N_INPUTS,
    parameter int unsigned SATURATE = DEF_SATURATE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_act,
    input  logic signed [W_W-1:0]   in_weight,
    input  logic                    in_last,
    input  logic signed [ACC_W-1:0] bias,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_raw,
    output logic signed [ACC_W-1:0] out_relu,
    output logic                    out_sat
);

    localparam int unsigned PROD_W = IN_W + W_W;
    localparam int unsigned CNT_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);

    state_e                  r_state;
    state_e                  w_next;
    logic [CNT_W-1:0]        r_count;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_sat;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic signed [ACC_W-1:0] r_out_raw;
    logic signed [ACC_W-1:0] r_out_relu;
    logic                    r_out_sat;

    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_base;
    logic signed [ACC_W-1:0]  w_sum;
    logic                     w_ovf;
    logic                     w_ovf_flag;
    logic                     w_accept;
    logic                     w_end;
    logic                     w_sum_pos;

    // Full-precision product, sign-extended into the accumulator width
    assign w_prod     = PROD_W'(in_act) * PROD_W'(in_weight);
    assign w_prod_ext = ACC_W'(w_prod);

    // First beat of a neuron starts from the bias rather than the running sum
    assign w_base     = (r_count == '0) ? bias : r_acc;
    assign w_accept   = in_valid && r_in_ready;
    assign w_end      = w_accept && (in_last || (r_count == CNT_LAST));
    assign w_ovf_flag = (SATURATE != 0) && w_ovf;
    assign w_sum_pos  = !w_sum[ACC_W-1] && (w_sum != '0);

    mlp_sat_add #(
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
    ) u_add (
        .i_a     (w_base),
        .i_b     (w_prod_ext),
        .o_sum_c (w_sum),
        .o_ovf_c (w_ovf)
    );

    // Next-state: accumulate until the final beat, then hold result until taken
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_ACCUM: if (w_end)     w_next = ST_EMIT;
            ST_EMIT:  if (out_ready) w_next = ST_ACCUM;
            default:                 w_next = ST_ACCUM;
        endcase
    end

    // State register with handshake flags registered alongside it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_ACCUM;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next == ST_ACCUM);
            r_out_valid <= (w_next == ST_EMIT);
        end
    end

    // Accumulator, beat counter, sticky saturation flag and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_acc      <= '0;
            r_sat      <= 1'b0;
            r_out_raw  <= '0;
            r_out_relu <= '0;
            r_out_sat  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_acc <= w_sum;
                r_sat <= r_sat | w_ovf_flag;
                if (w_end) begin
                    r_count    <= '0;
                    r_out_raw  <= w_sum;
                    r_out_relu <= w_sum_pos ? w_sum : '0;
                    r_out_sat  <= r_sat | w_ovf_flag;
                end else begin
                    r_count <= r_count + CNT_W'(1);
                end
            end
            if ((r_state == ST_EMIT) && out_ready) begin
                r_acc <= '0;
                r_sat <= 1'b0;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_raw   = r_out_raw;
    assign out_relu  = r_out_relu;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_mlp_neuron_mac.sv
// Scoreboard bench: saturating and wrapping instances driven by the same beats.
module tb_mlp_neuron_mac;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic signed [3:0]  in_act;
    logic signed [3:0]  in_weight;
    logic               in_last;
    logic signed [15:0] bias;
    logic               out_ready;

    logic               s_in_ready, s_out_valid, s_out_sat;
    logic signed [15:0] s_out_raw, s_out_relu;
    logic               w_in_ready, w_out_valid, w_out_sat;
    logic signed [15:0] w_out_raw, w_out_relu;

    typedef struct {
        logic [15:0] raw;
        logic [15:0] relu;
        logic        sat;
    } exp_t;

    exp_t q_s[$];
    exp_t q_w[$];

    int s_pass = 0, s_tot = 0;
    int m_pass = 0, m_tot = 0;

    mlp_neuron_mac #(.IN_W(4), .W_W(4), .ACC_W(16), .N_INPUTS(4), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_act(in_act), .in_weight(in_weight), .in_last(in_last), .bias(bias),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_raw(s_out_raw),
        .out_relu(s_out_relu), .out_sat(s_out_sat)
    );

    mlp_neuron_mac #(.IN_W(4), .W_W(4), .ACC_W(16), .N_INPUTS(4), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_act(in_act), .in_weight(in_weight), .in_last(in_last), .bias(bias),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_raw(w_out_raw),
        .out_relu(w_out_relu), .out_sat(w_out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pop and compare whenever a result handshake is about to complete
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_ready) begin
            if (s_out_valid) begin
                m_tot++;
                if (q_s.size() == 0) begin
                    $display("FAIL sat_unexpected_result: got raw=%0d, none expected", s_out_raw);
                end else begin
                    m_pass++;
                    e = q_s.pop_front();
                    m_tot++;
                    if (s_out_raw === e.raw) m_pass++;
                    else $display("FAIL sat_raw: got %h want %h", s_out_raw, e.raw);
                    m_tot++;
                    if (s_out_relu === e.relu) m_pass++;
                    else $display("FAIL sat_relu: got %h want %h", s_out_relu, e.relu);
                    m_tot++;
                    if (s_out_sat === e.sat) m_pass++;
                    else $display("FAIL sat_flag: got %b want %b", s_out_sat, e.sat);
                end
            end
            if (w_out_valid) begin
                m_tot++;
                if (q_w.size() == 0) begin
                    $display("FAIL wrap_unexpected_result: got raw=%0d, none expected", w_out_raw);
                end else begin
                    m_pass++;
                    e = q_w.pop_front();
                    m_tot++;
                    if (w_out_raw === e.raw) m_pass++;
                    else $display("FAIL wrap_raw: got %h want %h", w_out_raw, e.raw);
                    m_tot++;
                    if (w_out_relu === e.relu) m_pass++;
                    else $display("FAIL wrap_relu: got %h want %h", w_out_relu, e.relu);
                    m_tot++;
                    if (w_out_sat === e.sat) m_pass++;
                    else $display("FAIL wrap_flag: got %b want %b", w_out_sat, e.sat);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        s_tot++;
        if (act === exp) s_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic push_exp(input logic [15:0] s_raw, input logic [15:0] s_relu, input logic s_sat,
                            input logic [15:0] w_raw, input logic [15:0] w_relu);
        exp_t e;
        e.raw = s_raw; e.relu = s_relu; e.sat = s_sat;
        q_s.push_back(e);
        e.raw = w_raw; e.relu = w_relu; e.sat = 1'b0;
        q_w.push_back(e);
    endtask

    // Present one beat and hold it until the edge on which it is accepted
    task automatic send_beat(input int a, input int w, input logic last);
        int guard = 0;
        in_valid  = 1'b1;
        in_act    = 4'(a);
        in_weight = 4'(w);
        in_last   = last;
        while (!s_in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!s_in_ready) chk("beat_accept_timeout", 32'(s_in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    // After the final beat: result visible next cycle, dropped after handshake
    task automatic finish_neuron();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("sat_latency_valid",  32'(s_out_valid), 32'd1);
        chk("wrap_latency_valid", 32'(w_out_valid), 32'd1);
        @(posedge clk); #1;
        chk("sat_valid_drop",  32'(s_out_valid), 32'd0);
        chk("wrap_valid_drop", 32'(w_out_valid), 32'd0);
        chk("sat_ready_back",  32'(s_in_ready),  32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_act = '0; in_weight = '0;
        in_last = 1'b0; bias = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(s_out_valid), 32'd0);
        chk("rst_out_raw",   32'(s_out_raw),   32'd0);
        chk("rst_out_relu",  32'(s_out_relu),  32'd0);
        chk("rst_out_sat",   32'(s_out_sat),   32'd0);
        rst_n = 1'b1;
        chk("rst_in_ready",  32'(s_in_ready),  32'd1);

        // Test 1 + 4: mixed-sign beats, then hold the result under backpressure
        out_ready = 1'b0;
        bias = 16'sd0;
        push_exp(16'd114, 16'd114, 1'b0, 16'd114, 16'd114);
        send_beat(3, 2, 1'b0);
        send_beat(-1, 5, 1'b0);
        send_beat(7, 7, 1'b0);
        send_beat(-8, -8, 1'b0);
        chk("bp_latency_valid", 32'(s_out_valid), 32'd1);
        // Next neuron's first beat is offered while the result is stalled
        bias = -16'sd100; in_valid = 1'b1; in_act = 4'sd1; in_weight = 4'sd1; in_last = 1'b0;
        push_exp(16'hFFA0, 16'd0, 1'b0, 16'hFFA0, 16'd0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", 32'(s_out_valid), 32'd1);
            chk("bp_hold_raw",   32'(s_out_raw),   32'd114);
            chk("bp_hold_ready", 32'(s_in_ready),  32'd0);
            chk("bp_hold_ready_wrap", 32'(w_in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(s_out_valid), 32'd0);
        chk("bp_release_ready", 32'(s_in_ready),  32'd1);

        // Test 2: negative bias, result not positive so ReLU is zero
        for (int i = 0; i < 4; i++) send_beat(1, 1, 1'b0);
        finish_neuron();

        // Test 3: overflow clamps in one instance and wraps in the other
        bias = 16'sd32760;
        push_exp(16'd32767, 16'd32767, 1'b1, 16'h8029, 16'd0);
        send_beat(7, 7, 1'b0);
        for (int i = 0; i < 3; i++) send_beat(0, 0, 1'b0);
        finish_neuron();

        // Test 5: early termination after two beats
        bias = 16'sd10;
        push_exp(16'd12, 16'd12, 1'b0, 16'd12, 16'd12);
        send_beat(2, 3, 1'b0);
        send_beat(1, -4, 1'b1);
        finish_neuron();

        // Count restarted: a full four-beat neuron follows
        bias = -16'sd100;
        push_exp(16'hFFA0, 16'd0, 1'b0, 16'hFFA0, 16'd0);
        for (int i = 0; i < 4; i++) send_beat(1, 1, 1'b0);
        finish_neuron();

        // Test 6: reset mid-accumulation discards the partial sum
        bias = 16'sd0;
        send_beat(1, 1, 1'b0);
        send_beat(1, 1, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_out_valid", 32'(s_out_valid), 32'd0);
        chk("midrst_out_raw",   32'(s_out_raw),   32'd0);
        chk("midrst_out_relu",  32'(s_out_relu),  32'd0);
        chk("midrst_out_raw_wrap", 32'(w_out_raw), 32'd0);
        rst_n = 1'b1;
        chk("midrst_in_ready",  32'(s_in_ready),  32'd1);
        push_exp(16'd4, 16'd4, 1'b0, 16'd4, 16'd4);
        for (int i = 0; i < 4; i++) send_beat(1, 1, 1'b0);
        finish_neuron();

        repeat (3) @(posedge clk);
        #1;
        chk("sat_queue_drained",  32'(q_s.size()), 32'd0);
        chk("wrap_queue_drained", 32'(q_w.size()), 32'd0);

        $display("%0d/%0d checks passed", s_pass + m_pass, s_tot + m_tot);
        $finish;
    end

endmodule

// File: doc/mlp_neuron_mac.md
Name: mlp_neuron_mac

Overview:
Parametrised single-neuron multiply-accumulate engine for the tiny-MLP datapath. It streams (input, weight) pairs through a valid/ready handshake and accumulates signed products onto a bias for a fan-in of up to N_INPUTS beats. It then presents the raw sum and its ReLU through an output handshake. It generalises the gen-1 single-product combinational step: widths, fan-in and overflow mode are configurable, and sequencing, bias and backpressure are internal.

Parameters:
IN_W, 4, signed activation width
W_W, 4, signed weight width
ACC_W, 16, signed accumulator/bias/output width; must be >= IN_W+W_W
N_INPUTS, 4, maximum fan-in beats per neuron (>=1)
SATURATE, 1, 1 = saturating accumulate; 0 = two's-complement wrap (gen-1 behaviour)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  beat valid
in_ready  out  1  block accepts beat
in_act  in  IN_W  signed activation
in_weight  in  W_W  signed weight
in_last  in  1  final beat of this neuron (early termination)
bias  in  ACC_W  signed bias, sampled on first beat of each neuron
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_raw  out  ACC_W  signed accumulated sum
out_relu  out  ACC_W  out_raw if out_raw > 0, else 0
out_sat  out  1  saturation occurred during this neuron (always 0 when SATURATE=0)

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- Reset state: ACCUM; count=0; acc=0; sat flag=0; out_valid=0; out_raw=0; out_relu=0; out_sat=0; in_ready=1 on the first cycle after reset is released.
- States:
  - ACCUM: in_ready=1, out_valid=0. A beat is accepted when in_valid && in_ready.
  - EMIT: in_ready=0, out_valid=1. Outputs are stable until accepted.
- Product: signed in_act*in_weight, full IN_W+W_W bits, sign-extended to ACC_W.
- Accepted beat with count==0: sum = bias + prod. Otherwise: sum = acc + prod.
- SATURATE=1: on signed overflow, clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1), and set the sat flag (sticky until the neuron completes). SATURATE=0: wrap.
- End condition: accepted beat with in_last=1, or count==N_INPUTS-1. On end, go to EMIT, register out_raw/out_relu/out_sat, and clear count. Otherwise count++.
- Latency: out_valid rises the cycle after the final beat is accepted.
- EMIT with out_valid && out_ready: return to ACCUM, clear acc and sat flag. out_valid drops next cycle. No same-cycle acceptance of a new beat (in_ready=0 in EMIT); throughput is fan-in + 1 cycles per neuron.
- in_valid with in_ready=0 is ignored. The sender holds data per the standard valid/ready rule.
- out_relu for zero or negative out_raw is 0. The ReLU compare is a strict signed > 0.
- Reset mid-accumulation or mid-EMIT discards the partial sum and pending result, then returns to the reset state.
- count width: max(1, $clog2(N_INPUTS)).

Decomposition:
- Shared package mlp_pkg:
  - state enum (ST_ACCUM, ST_EMIT)
  - default width localparams
  - function for signed clamp limits
- Sub-module mlp_sat_add (ACC_W, SATURATE): combinational a+b producing sum and overflow. It is reused by later layer blocks.
- Product, counter and FSM live in mlp_neuron_mac.

Test Plan:
1. Defaults, bias=0, beats (3,2),(-1,5),(7,7),(-8,-8), in_valid held -> one cycle after 4th beat: out_valid=1, out_raw=114, out_relu=114, out_sat=0.
2. bias=-100, four beats (1,1) -> out_raw=-96 (16'hFFA0), out_relu=0.
3. bias=32760, beats (7,7),(0,0),(0,0),(0,0) with SATURATE=1 -> out_raw=32767, out_sat=1. Same stimulus with SATURATE=0 -> out_raw=16'h8029 (-32727), out_relu=0, out_sat=0.
4. Backpressure: after test 1 result, out_ready=0 for 5 cycles while in_valid=1 -> outputs held at 114, in_ready=0, no beats consumed. Then out_ready=1 -> out_valid=0 next cycle, in_ready=1, next neuron starts from its bias.
5. Early termination: bias=10, beats (2,3),(1,-4) with in_last on beat 2 -> out_raw=12, out_valid one cycle later, count restarts at 0.
6. rst_n=0 for one cycle after 2 of 4 beats -> all outputs 0, in_ready=1. A fresh neuron (bias 0, four beats (1,1)) yields out_raw=4.
